// File: rtl/flag_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : flag_unit_if
// Description : Bundle between the EX/ID pipeline control and the flag unit.
//               master = pipeline side (drives EX/ID info, reads results)
//               slave  = flag unit (consumes EX/ID info, produces results)
// Signals     : ex_valid, ex_opcode[3:0], alu_flag[2:0] {Z,V,N}, stall, flush,
//               br_req, br_ccc[2:0]            -> towards the flag unit
//               flags_q[2:0] {Z,V,N}, br_taken, br_stall -> from the flag unit
// Revision    : 1.0  initial release
// ============================================================================
interface flag_unit_if;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [2:0] alu_flag;
    logic       stall;
    logic       flush;
    logic       br_req;
    logic [2:0] br_ccc;
    logic [2:0] flags_q;
    logic       br_taken;
    logic       br_stall;

    modport master (
        output ex_valid, ex_opcode, alu_flag, stall, flush, br_req, br_ccc,
        input  flags_q, br_taken, br_stall
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_flag, stall, flush, br_req, br_ccc,
        output flags_q, br_taken, br_stall
    );
endinterface
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_unit
// Description : Architectural Z/V/N flag register and branch-condition
//               evaluator sitting right after the EX-stage ALU/shifter.
//               Commits EX flags under a per-opcode update mask, evaluates
//               the ID branch condition against (optionally bypassed) flags,
//               and raises a hazard stall when bypassing is disabled.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous reset, active-high
//               bus      - flag_unit_if.slave (EX info, ID branch request,
//                          flags_q / br_taken / br_stall results)
// Parameters  : BYPASS      - 1: ID sees flags written by EX this cycle
//                             0: hazard reported on br_stall instead
//               RESET_FLAGS - flag register reset value {Z,V,N}
// Revision    : 1.0  initial release
// ============================================================================
module flag_unit #(
    parameter bit         BYPASS      = 1'b1,
    parameter logic [2:0] RESET_FLAGS = 3'b000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    flag_unit_if.slave bus
);

    // Flag bit positions inside every {Z,V,N} vector
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_V = 1;
    localparam int c_FLAG_N = 0;

    // Opcodes that touch the flags; everything else leaves them alone
    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_XOR = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRA = 4'b0101;
    localparam logic [3:0] c_OP_ROR = 4'b0110;

    localparam logic [2:0] c_MASK_ALL  = 3'b111;
    localparam logic [2:0] c_MASK_Z    = 3'b100;
    localparam logic [2:0] c_MASK_NONE = 3'b000;

    // Branch condition codes
    localparam logic [2:0] c_CC_NEQ  = 3'b000;
    localparam logic [2:0] c_CC_EQ   = 3'b001;
    localparam logic [2:0] c_CC_GT   = 3'b010;
    localparam logic [2:0] c_CC_LT   = 3'b011;
    localparam logic [2:0] c_CC_GTE  = 3'b100;
    localparam logic [2:0] c_CC_LTE  = 3'b101;
    localparam logic [2:0] c_CC_OVFL = 3'b110;
    localparam logic [2:0] c_CC_UNC  = 3'b111;

    logic [2:0] r_flags;
    logic [2:0] w_mask;
    logic       w_wr;
    logic [2:0] w_eff;
    logic       w_cond;
    logic       w_br_stall;

    // ------------------------------------------------------------------
    // Update-mask decode. RED, PADDSB, the whole 1xxx space and any
    // unknown opcode fall through to an empty mask, so X on the opcode
    // can never leak into the flag register.
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = c_MASK_NONE;
        case (bus.ex_opcode)
            c_OP_ADD, c_OP_SUB:                     w_mask = c_MASK_ALL;
            c_OP_XOR, c_OP_SLL, c_OP_SRA, c_OP_ROR: w_mask = c_MASK_Z;
            default:                                w_mask = c_MASK_NONE;
        endcase
    end

    // A stalled instruction waits; a flushed one is dropped for good.
    assign w_wr = bus.ex_valid & ~bus.stall & ~bus.flush;

    // ------------------------------------------------------------------
    // Architectural flag register. Bits outside the mask keep their value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= RESET_FLAGS;
        end else if (w_wr) begin
            r_flags <= (r_flags & ~w_mask) | (bus.alu_flag & w_mask);
        end
    end

    // ------------------------------------------------------------------
    // Effective flags seen by the ID branch and hazard detection.
    // ------------------------------------------------------------------
    generate
        if (BYPASS) begin : g_bypass
            // Forward the bits EX is committing this cycle. A stalled
            // flag-setter has w_wr=0 and is not forwarded; holding ID in
            // that case is the pipeline controller's job.
            assign w_eff      = ((w_wr ? w_mask : c_MASK_NONE) & bus.alu_flag) |
                                (~(w_wr ? w_mask : c_MASK_NONE) & r_flags);
            assign w_br_stall = 1'b0;
        end else begin : g_no_bypass
            // Any live flag-setter in EX makes the committed flags stale
            // for the branch; stall ID until it has been written.
            assign w_eff      = r_flags;
            assign w_br_stall = bus.br_req & bus.ex_valid & ~bus.flush & (|w_mask);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Condition evaluation on {Z,V,N}.
    // ------------------------------------------------------------------
    always_comb begin
        w_cond = 1'b0;
        case (bus.br_ccc)
            c_CC_NEQ:  w_cond = ~w_eff[c_FLAG_Z];
            c_CC_EQ:   w_cond =  w_eff[c_FLAG_Z];
            c_CC_GT:   w_cond = ~w_eff[c_FLAG_Z] & ~w_eff[c_FLAG_N];
            c_CC_LT:   w_cond =  w_eff[c_FLAG_N];
            c_CC_GTE:  w_cond =  w_eff[c_FLAG_Z] | (~w_eff[c_FLAG_Z] & ~w_eff[c_FLAG_N]);
            c_CC_LTE:  w_cond =  w_eff[c_FLAG_N] |  w_eff[c_FLAG_Z];
            c_CC_OVFL: w_cond =  w_eff[c_FLAG_V];
            c_CC_UNC:  w_cond = 1'b1;
            default:   w_cond = 1'b0;
        endcase
    end

    assign bus.flags_q  = r_flags;
    assign bus.br_taken = bus.br_req & w_cond;
    assign bus.br_stall = w_br_stall;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_unit
// Description : Self-checking bench for flag_unit. Two instances share one
//               stimulus stream: one with BYPASS=1, one with BYPASS=0.
//               Directed table rows with hand-derived expectations, a
//               reset-during-hazard sequence, then random cycles checked
//               against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_flag_unit;

    localparam logic [2:0] c_RESET_FLAGS = 3'b000;

    logic clk;
    logic rst;

    flag_unit_if bus1 ();
    flag_unit_if bus0 ();

    flag_unit #(.BYPASS(1'b1), .RESET_FLAGS(c_RESET_FLAGS)) u_dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    flag_unit #(.BYPASS(1'b0), .RESET_FLAGS(c_RESET_FLAGS)) u_dut_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ex_valid;
        logic [3:0] opcode;
        logic [2:0] alu_flag;
        logic       stall;
        logic       flush;
        logic       br_req;
        logic [2:0] ccc;
        logic [2:0] e_flags;   // flags_q seen during this cycle
        logic       e_tk1;     // br_taken, bypassing instance
        logic       e_tk0;     // br_taken, non-bypassing instance
        logic       e_st0;     // br_stall, non-bypassing instance
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: the architectural flags
    logic [2:0] m_flags;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] op,
                                input logic [2:0] af, input logic st, input logic fl,
                                input logic bq, input logic [2:0] cc, input logic [2:0] ef,
                                input logic t1, input logic t0, input logic s0);
        vec_t x;
        x.rst = r;  x.ex_valid = v; x.opcode = op; x.alu_flag = af;
        x.stall = st; x.flush = fl; x.br_req = bq; x.ccc = cc;
        x.e_flags = ef; x.e_tk1 = t1; x.e_tk0 = t0; x.e_st0 = s0;
        return x;
    endfunction

    // Which flags each opcode writes, {Z,V,N}
    function automatic logic [2:0] model_mask(input logic [3:0] op);
        logic [2:0] tbl [16];
        for (int k = 0; k < 16; k++) tbl[k] = 3'b000;
        tbl[0] = 3'b111;  // ADD
        tbl[1] = 3'b111;  // SUB
        tbl[2] = 3'b100;  // XOR
        tbl[4] = 3'b100;  // SLL
        tbl[5] = 3'b100;  // SRA
        tbl[6] = 3'b100;  // ROR
        if ($isunknown(op)) return 3'b000;
        return tbl[op];
    endfunction

    function automatic logic model_cond(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Fill in the expected outputs of a vector from the model state
    function automatic vec_t model_expect(input vec_t x, input logic [2:0] flags);
        vec_t y;
        logic       wr;
        logic [2:0] msk;
        logic [2:0] eff1;
        y    = x;
        wr   = x.ex_valid && !x.stall && !x.flush;
        msk  = model_mask(x.opcode);
        for (int b = 0; b < 3; b++)
            eff1[b] = (wr && msk[b]) ? x.alu_flag[b] : flags[b];
        y.e_flags = flags;
        y.e_tk1   = x.br_req && model_cond(x.ccc, eff1);
        y.e_tk0   = x.br_req && model_cond(x.ccc, flags);
        y.e_st0   = x.br_req && x.ex_valid && !x.flush && (msk != 3'b000);
        return y;
    endfunction

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst            = x.rst;
        bus1.ex_valid  = x.ex_valid;  bus0.ex_valid  = x.ex_valid;
        bus1.ex_opcode = x.opcode;    bus0.ex_opcode = x.opcode;
        bus1.alu_flag  = x.alu_flag;  bus0.alu_flag  = x.alu_flag;
        bus1.stall     = x.stall;     bus0.stall     = x.stall;
        bus1.flush     = x.flush;     bus0.flush     = x.flush;
        bus1.br_req    = x.br_req;    bus0.br_req    = x.br_req;
        bus1.br_ccc    = x.ccc;       bus0.br_ccc    = x.ccc;
    endtask

    // One cycle: drive, compare away from the edge, then advance the model.
    task automatic step(input vec_t x, input string tag);
        logic [2:0] msk;
        drive(x);
        @(negedge clk);
        chk({tag, " flags_q byp"},   bus1.flags_q,  x.e_flags);
        chk({tag, " flags_q nobyp"}, bus0.flags_q,  x.e_flags);
        chk({tag, " br_taken byp"},  {2'b00, bus1.br_taken}, {2'b00, x.e_tk1});
        chk({tag, " br_taken nobyp"},{2'b00, bus0.br_taken}, {2'b00, x.e_tk0});
        chk({tag, " br_stall nobyp"},{2'b00, bus0.br_stall}, {2'b00, x.e_st0});
        chk({tag, " br_stall byp"},  {2'b00, bus1.br_stall}, 3'b000);
        @(posedge clk);
        msk = model_mask(x.opcode);
        if (x.rst)
            m_flags = c_RESET_FLAGS;
        else if (x.ex_valid && !x.stall && !x.flush)
            m_flags = (m_flags & ~msk) | (x.alu_flag & msk);
        #1;
    endtask

    vec_t tbl [24];
    vec_t rv;

    initial begin
        // Rows: rst, valid, opcode, alu_flag, stall, flush, br_req, ccc,
        //       exp flags_q, exp taken(byp), exp taken(nobyp), exp stall(nobyp)
        tbl[0]  = mk(0,0,4'b0000,3'b000,0,0,1,3'b111, 3'b000,1,1,0); // UNC after reset
        tbl[1]  = mk(0,0,4'b0000,3'b000,0,0,1,3'b001, 3'b000,0,0,0); // EQ with Z=0
        tbl[2]  = mk(0,1,4'b0000,3'b011,0,0,1,3'b011, 3'b000,1,0,1); // ADD, LT bypassed
        tbl[3]  = mk(0,0,4'b0000,3'b000,0,0,1,3'b011, 3'b011,1,1,0); // ADD committed
        tbl[4]  = mk(0,0,4'b0000,3'b000,0,0,1,3'b110, 3'b011,1,1,0); // OVFL
        tbl[5]  = mk(0,0,4'b0000,3'b000,0,0,1,3'b010, 3'b011,0,0,0); // GT false
        tbl[6]  = mk(0,1,4'b0100,3'b111,0,0,1,3'b001, 3'b011,1,0,1); // SLL: Z only
        tbl[7]  = mk(0,1,4'b0011,3'b000,0,0,1,3'b101, 3'b111,1,1,0); // RED: no write
        tbl[8]  = mk(0,0,4'b0000,3'b000,0,0,0,3'b000, 3'b111,0,0,0);
        tbl[9]  = mk(0,1,4'b0000,3'b000,0,0,0,3'b000, 3'b111,0,0,0); // ADD -> 000
        tbl[10] = mk(0,1,4'b0001,3'b100,0,1,1,3'b001, 3'b000,0,0,0); // flushed SUB
        tbl[11] = mk(0,1,4'b0001,3'b100,0,0,1,3'b001, 3'b000,1,0,1); // SUB, EQ bypassed
        tbl[12] = mk(0,0,4'b0000,3'b000,0,0,1,3'b001, 3'b100,1,1,0);
        tbl[13] = mk(0,1,4'b0001,3'b010,1,0,1,3'b000, 3'b100,0,0,1); // stalled SUB x3
        tbl[14] = mk(0,1,4'b0001,3'b010,1,0,1,3'b000, 3'b100,0,0,1);
        tbl[15] = mk(0,1,4'b0001,3'b010,1,0,1,3'b000, 3'b100,0,0,1);
        tbl[16] = mk(0,1,4'b0001,3'b010,0,0,1,3'b000, 3'b100,1,0,1); // stall drops
        tbl[17] = mk(0,0,4'b0000,3'b000,0,0,1,3'b000, 3'b010,1,1,0);
        tbl[18] = mk(0,1,4'b0001,3'b101,1,1,1,3'b000, 3'b010,1,1,0); // stall+flush x3
        tbl[19] = mk(0,1,4'b0001,3'b101,1,1,1,3'b000, 3'b010,1,1,0);
        tbl[20] = mk(0,1,4'b0001,3'b101,1,1,1,3'b000, 3'b010,1,1,0);
        tbl[21] = mk(0,0,4'b0000,3'b000,0,0,0,3'b000, 3'b010,0,0,0); // never committed
        tbl[22] = mk(0,1,4'b1010,3'b111,0,0,1,3'b110, 3'b010,1,1,0); // 1xxx: no write
        tbl[23] = mk(0,0,4'b0000,3'b000,0,0,0,3'b000, 3'b010,0,0,0);

        // Reset for two cycles
        drive(mk(1,0,4'b0000,3'b000,0,0,0,3'b000, 3'b000,0,0,0));
        m_flags = c_RESET_FLAGS;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++)
            step(tbl[i], $sformatf("row%0d", i));

        // Reset arriving together with a flag write during a hazard:
        // reset wins and the write is lost.
        step(mk(1,1,4'b0000,3'b111,0,0,1,3'b001, 3'b010,1,0,1), "rst_hazard");
        step(mk(0,0,4'b0000,3'b000,0,0,1,3'b001, 3'b000,0,0,0), "after_rst");

        // Random cycles against the behavioural model
        for (int n = 0; n < 600; n++) begin
            rv.rst      = ($urandom_range(0, 39) == 0);
            rv.ex_valid = ($urandom_range(0, 3) != 0);
            rv.opcode   = 4'($urandom_range(0, 15));
            rv.alu_flag = 3'($urandom_range(0, 7));
            rv.stall    = ($urandom_range(0, 4) == 0);
            rv.flush    = ($urandom_range(0, 5) == 0);
            rv.br_req   = ($urandom_range(0, 2) != 0);
            rv.ccc      = 3'($urandom_range(0, 7));
            rv = model_expect(rv, m_flags);
            step(rv, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Flag register and branch-condition evaluator, directly downstream of the execute-stage ALU/shifter.
- Consumes the 3-bit flag vector produced in EX and commits it to an architectural Z/V/N register, using a per-opcode update mask.
- Evaluates the 3-bit branch condition code for the branch in ID against forwarded (EX-bypassed) flags.
- Produces the taken decision for fetch redirect, or a stall request when bypassing is disabled.

Parameters:
- BYPASS, 1: 1 = ID branch sees flags being written by EX this cycle; 0 = hazard raised via br_stall instead.
- RESET_FLAGS, 3'b000: flag register value after reset, bit order {Z,V,N}.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_opcode  in  4  opcode of the EX instruction
- alu_flag  in  3  flags from ALU/shifter for the EX instruction; bit2=Z, bit1=V, bit0=N (same indices as `FLAG_Z/`FLAG_V/`FLAG_N)
- stall  in  1  EX stage held this cycle
- flush  in  1  EX instruction squashed this cycle
- br_req  in  1  ID holds a conditional branch (B or BR)
- br_ccc  in  3  branch condition code
- flags_q  out  3  committed flag register {Z,V,N}
- br_taken  out  1  branch condition satisfied (combinational)
- br_stall  out  1  ID must stall for a flag hazard (BYPASS=0 only; tied 0 when BYPASS=1)

Behaviour:
- Update mask, decoded from ex_opcode as mask{Z,V,N}:
  - 0000 ADD, 0001 SUB: 111
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: 100
  - 0011 RED, 0111 PADDSB, all opcodes 1xxx: 000
- Commit enable: wr = ex_valid & ~stall & ~flush.
- Register update, rising clk, priority order:
  - rst: flags_q <= RESET_FLAGS.
  - else if wr: flags_q[i] <= mask[i] ? alu_flag[i] : flags_q[i], for each bit independently.
  - else: hold.
- Reset value of outputs: flags_q = RESET_FLAGS. br_taken and br_stall are combinational; with ex_valid=0 and br_req=0 both are 0.
- Write latency: flags written in cycle N appear on flags_q in cycle N+1.
- Stalled EX instruction: does not commit while stall=1; commits once, in the first cycle stall=0 and flush=0. Re-presenting the same values is idempotent.
- Flushed EX instruction: never commits, even if stall is also high.
- rst in the same cycle as wr: reset wins, and the write is lost.
- Effective flags eff[i] for branch evaluation:
  - BYPASS=1: eff[i] = (wr & mask[i]) ? alu_flag[i] : flags_q[i].
  - BYPASS=0: eff = flags_q.
- Condition codes, on eff {Z,V,N}:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OVFL: V=1
  - 111 UNC: 1
- br_taken = br_req & cond(br_ccc, eff). It is 0 whenever br_req=0.
- br_stall (BYPASS=0) = br_req & ex_valid & ~flush & (|mask). While br_stall=1, br_taken is computed from stale flags and must be ignored by fetch. br_stall clears in the cycle after the producing instruction commits.
- A stalled EX flag-setter with BYPASS=1: wr=0, so eff = flags_q. The pipeline controller must also hold ID in this case, and this block does not detect it.
- No X propagation: an unknown opcode gives mask=000.

Test Plan:
- Reset: rst=1 for 2 cycles with RESET_FLAGS=000 -> flags_q=000; br_req=1, br_ccc=111 -> br_taken=1; br_ccc=001 -> br_taken=0.
- ADD commit: ex_valid=1, opcode=0000, alu_flag=3'b011 -> next cycle flags_q=011. Then br_ccc=011 (LT) -> br_taken=1; br_ccc=110 (OVFL) -> 1; br_ccc=010 (GT) -> 0.
- Partial mask: flags_q=011, then SLL with alu_flag=3'b111 -> flags_q=111 (Z updated, V/N kept at 1). Then RED with alu_flag=000 -> flags_q stays 111.
- Bypass (BYPASS=1): flags_q=000; same cycle SUB with alu_flag=100 and br_req=1, br_ccc=001 -> br_taken=1 in that cycle; with flush=1 instead -> br_taken=0 and flags_q stays 000.
- Stall/flush: SUB alu_flag=010 held with stall=1 for 3 cycles -> flags_q unchanged; stall drops -> flags_q=010 next cycle. Repeat with stall=1 and flush=1 together -> never commits.
- Hazard (BYPASS=0): ADD in EX, br_req=1 -> br_stall=1 for that cycle. Next cycle ex_valid=0 -> br_stall=0 and br_taken reflects the committed ADD flags. rst asserted mid-hazard -> flags_q=RESET_FLAGS the next cycle.
